// File: rtl/smbm_cmd_ctrl.sv
// Command controller for the sorted-metric bitmap list manager.
// Queues ADD/DELETE/READ requests, issues them one at a time to the list
// manager, waits (with timeout) for completion and returns a response.
// Tracks the list occupancy so that ADD-when-full and DELETE-when-empty are
// rejected locally without touching the list manager.
module smbm_cmd_ctrl #(
    parameter int unsigned BIT_VEC_SIZE       = 128,
    parameter int unsigned BIT_VEC_SIZE_LOG   = 7,
    parameter int unsigned NUM_OF_METRICS     = 4,
    parameter int unsigned NUM_OF_METRICS_LOG = 2,
    parameter int unsigned FIFO_DEPTH         = 4,  // power of 2, >= 2
    parameter int unsigned TIMEOUT            = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    // Request channel
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [1:0]                    req_op,
    input  logic [BIT_VEC_SIZE_LOG-1:0]   req_id,
    input  logic [8*NUM_OF_METRICS-1:0]   req_metric,
    input  logic [BIT_VEC_SIZE-1:0]       req_in,
    input  logic [NUM_OF_METRICS_LOG-1:0] req_metricX,
    input  logic [2:0]                    req_rd_mode,
    // List-manager channel
    output logic [2:0]                    sm_opcode,
    output logic [2:0]                    sm_opcode_in,
    output logic [BIT_VEC_SIZE_LOG-1:0]   sm_id,
    output logic [7:0]                    sm_metric_val [NUM_OF_METRICS],
    output logic [BIT_VEC_SIZE-1:0]       sm_in,
    output logic [NUM_OF_METRICS_LOG-1:0] sm_metricX,
    input  logic                          sm_done,
    // Response channel
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [1:0]                    rsp_op,
    output logic [1:0]                    rsp_err,
    output logic [BIT_VEC_SIZE_LOG:0]     occupancy
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam int unsigned OW = BIT_VEC_SIZE_LOG + 1;

    localparam logic [1:0] OpAdd  = 2'd0;
    localparam logic [1:0] OpDel  = 2'd1;
    localparam logic [1:0] OpRead = 2'd2;

    localparam logic [1:0] ErrOk      = 2'd0;
    localparam logic [1:0] ErrFull    = 2'd1;
    localparam logic [1:0] ErrEmpty   = 2'd2;
    localparam logic [1:0] ErrTimeout = 2'd3;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StIssue = 2'd1;
    localparam logic [1:0] StWait  = 2'd2;
    localparam logic [1:0] StResp  = 2'd3;

    localparam logic [OW-1:0] OccMax = OW'(BIT_VEC_SIZE);

    typedef struct packed {
        logic [1:0]                    op;
        logic [BIT_VEC_SIZE_LOG-1:0]   id;
        logic [8*NUM_OF_METRICS-1:0]   metric;
        logic [BIT_VEC_SIZE-1:0]       vec;
        logic [NUM_OF_METRICS_LOG-1:0] mx;
        logic [2:0]                    rd_mode;
    } req_t;

    req_t            fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   cnt_q;
    logic            fifo_full, fifo_empty, push, pop;
    req_t            req_word, head;

    logic [1:0]      state_q, state_d;
    req_t            arg_q, arg_d;
    logic [1:0]      rsp_op_q, rsp_op_d;
    logic [1:0]      rsp_err_q, rsp_err_d;
    logic [OW-1:0]   occ_q, occ_d;
    logic [TW-1:0]   tmr_q, tmr_d;

    assign req_word = '{op: req_op, id: req_id, metric: req_metric, vec: req_in,
                        mx: req_metricX, rd_mode: req_rd_mode};
    assign head       = fifo_mem[rd_ptr_q];
    assign fifo_full  = (cnt_q == CW'(FIFO_DEPTH));
    assign fifo_empty = (cnt_q == '0);
    // No bypass: a pop in this cycle does not make room until the next one.
    assign req_ready  = !fifo_full;
    assign push       = req_valid && req_ready;
    assign pop        = (state_q == StIdle) && !fifo_empty;

    // Request storage; contents need no reset since cnt_q qualifies them.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= req_word;
        end
    end

    // FIFO pointers and fill count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push && !pop)      cnt_q <= cnt_q + CW'(1);
            else if (pop && !push) cnt_q <= cnt_q - CW'(1);
        end
    end

    // Next-state logic for the issue FSM, response fields and occupancy.
    always_comb begin
        state_d   = state_q;
        arg_d     = arg_q;
        rsp_op_d  = rsp_op_q;
        rsp_err_d = rsp_err_q;
        occ_d     = occ_q;
        tmr_d     = tmr_q;
        unique case (state_q)
            StIdle: begin
                if (pop) begin
                    arg_d    = head;
                    rsp_op_d = head.op;
                    state_d  = StIssue;
                    if (head.op == 2'd3) begin
                        rsp_err_d = ErrEmpty;
                        state_d   = StResp;
                    end else if (head.op == OpAdd && occ_q == OccMax) begin
                        rsp_err_d = ErrFull;
                        state_d   = StResp;
                    end else if (head.op == OpDel && occ_q == '0) begin
                        rsp_err_d = ErrEmpty;
                        state_d   = StResp;
                    end
                end
            end
            StIssue: begin
                tmr_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                if (sm_done) begin
                    rsp_err_d = ErrOk;
                    state_d   = StResp;
                    if (arg_q.op == OpAdd && occ_q != OccMax) occ_d = occ_q + OW'(1);
                    if (arg_q.op == OpDel && occ_q != '0)     occ_d = occ_q - OW'(1);
                end else if (tmr_q == TW'(TIMEOUT - 1)) begin
                    rsp_err_d = ErrTimeout;
                    state_d   = StResp;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            StResp: begin
                if (rsp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM and argument/response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            arg_q     <= '0;
            rsp_op_q  <= '0;
            rsp_err_q <= '0;
            occ_q     <= '0;
            tmr_q     <= '0;
        end else begin
            state_q   <= state_d;
            arg_q     <= arg_d;
            rsp_op_q  <= rsp_op_d;
            rsp_err_q <= rsp_err_d;
            occ_q     <= occ_d;
            tmr_q     <= tmr_d;
        end
    end

    // List-manager outputs; arguments come straight from the held argument register.
    always_comb begin
        sm_opcode = 3'b111;
        if (state_q == StIssue) begin
            unique case (arg_q.op)
                OpAdd:   sm_opcode = 3'b000;
                OpDel:   sm_opcode = 3'b001;
                OpRead:  sm_opcode = 3'b010;
                default: sm_opcode = 3'b111;
            endcase
        end
        for (int k = 0; k < NUM_OF_METRICS; k++) begin
            sm_metric_val[k] = arg_q.metric[8*k +: 8];
        end
    end

    assign sm_opcode_in = arg_q.rd_mode;
    assign sm_id        = arg_q.id;
    assign sm_in        = arg_q.vec;
    assign sm_metricX   = arg_q.mx;
    assign rsp_valid    = (state_q == StResp);
    assign rsp_op       = rsp_op_q;
    assign rsp_err      = rsp_err_q;
    assign occupancy    = occ_q;

endmodule
